// File: rtl/imm_enc_pkg.sv
// Shared types and constants for the RV32I immediate encoder / LI expander.
package imm_enc_pkg;

  typedef enum logic [2:0] {
    FMT_I  = 3'b000,
    FMT_S  = 3'b001,
    FMT_B  = 3'b010,
    FMT_J  = 3'b011,
    FMT_U  = 3'b100,
    FMT_LI = 3'b111
  } imm_fmt_e;

  typedef enum logic {
    ST_IDLE,
    ST_LI_ADDI
  } enc_state_e;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  // Signed limits; B and J upper bounds are the largest even offsets.
  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] IMM13_MIN = -32'sd4096;
  localparam logic signed [31:0] IMM13_MAX = 32'sd4094;
  localparam logic signed [31:0] IMM21_MIN = -32'sd1048576;
  localparam logic signed [31:0] IMM21_MAX = 32'sd1048574;

endpackage

// File: rtl/imm_encoder_imm_pack.sv
// Combinational immediate scatter: places imm bits into the instruction
// fields of the selected format and flags values that do not fit.
module imm_pack
  import imm_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic [31:0] fields,
  output logic        range_err
);

  logic signed [31:0] imm_s;
  assign imm_s = $signed(imm);

  always_comb begin
    fields    = '0;
    range_err = 1'b0;
    case (fmt)
      FMT_I: begin
        fields    = {imm[11:0], 20'b0};
        range_err = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
      end
      FMT_S: begin
        fields    = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        range_err = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
      end
      FMT_B: begin
        fields    = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        range_err = (imm_s < IMM13_MIN) || (imm_s > IMM13_MAX) || imm[0];
      end
      FMT_J: begin
        fields    = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        range_err = (imm_s < IMM21_MIN) || (imm_s > IMM21_MAX) || imm[0];
      end
      FMT_U: begin
        fields    = {imm[31:12], 12'b0};
        range_err = |imm[11:0];
      end
      FMT_LI: begin
        fields    = '0;
        range_err = 1'b0;
      end
      // Reserved codes leave the template untouched but are always flagged.
      default: begin
        fields    = '0;
        range_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Encodes an immediate into an RV32I template word and expands LI into
// ADDI or LUI+ADDI, behind a single registered valid/ready output stage.
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int unsigned CHECK_RANGE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [31:0] in_base,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  enc_state_e  state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_err_q, out_err_d;
  logic        out_last_q, out_last_d;
  logic [31:0] pend_q, pend_d;

  logic [31:0] pack_fields;
  logic        pack_err;
  logic        accept;
  logic        li_small;
  logic [19:0] li_hi;
  logic [4:0]  rd;

  imm_pack u_pack (
    .fmt       (in_fmt),
    .imm       (in_imm),
    .fields    (pack_fields),
    .range_err (pack_err)
  );

  assign in_ready  = !reset && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign out_last  = out_last_q;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    out_last_d  = out_last_q;
    pend_d      = pend_q;
    accept      = in_valid && in_ready;
    rd          = in_base[11:7];
    li_small    = ($signed(in_imm) >= IMM12_MIN) && ($signed(in_imm) <= IMM12_MAX);
    // Round the upper part so the sign-extended ADDI low part lands back on imm.
    li_hi       = in_imm[31:12] + {19'b0, in_imm[11]};

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          if (in_fmt == FMT_LI) begin
            out_err_d = 1'b0;
            if (li_small) begin
              out_instr_d = {in_imm[11:0], 5'd0, 3'b000, rd, OPC_OPIMM};
              out_last_d  = 1'b1;
            end else begin
              out_instr_d = {li_hi, rd, OPC_LUI};
              out_last_d  = (in_imm[11:0] == 12'd0);
              pend_d      = {in_imm[11:0], rd, 3'b000, rd, OPC_OPIMM};
              if (in_imm[11:0] != 12'd0) state_d = ST_LI_ADDI;
            end
          end else begin
            out_instr_d = in_base | pack_fields;
            out_err_d   = (CHECK_RANGE != 0) && pack_err;
            out_last_d  = 1'b1;
          end
        end
      end
      ST_LI_ADDI: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b1;
          out_instr_d = pend_q;
          out_err_d   = 1'b0;
          out_last_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      out_last_q  <= out_last_d;
      pend_q      <= pend_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vectors, stalls, reset
// during LI, streaming, and randomized traffic against a behavioural model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = 3'd0;
  logic [31:0] in_base = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_last;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic        last;
  } word_t;
  word_t exp_q[$];

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_base   (in_base),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .out_last  (out_last)
  );

  // Reference model: appends the word(s) one request must produce.
  function automatic void model(input logic [2:0] f, input logic [31:0] base, input logic [31:0] imm);
    word_t w;
    int s, t, lo;
    logic [31:0] rd, hi;
    s = $signed(imm);
    w.last = 1'b1;
    w.err = 1'b0;
    case (f)
      3'd0: begin
        w.instr = base | ((imm & 32'hFFF) << 20);
        w.err = (s < -2048) || (s > 2047);
      end
      3'd1: begin
        w.instr = base | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
        w.err = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w.instr = base | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
        w.err = (s < -4096) || (s > 4094) || imm[0];
      end
      3'd3: begin
        w.instr = base | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                | (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000FF000);
        w.err = (s < -1048576) || (s > 1048574) || imm[0];
      end
      3'd4: begin
        w.instr = base | (imm & 32'hFFFFF000);
        w.err = (imm & 32'hFFF) != 0;
      end
      3'd7: begin
        rd = (base >> 7) & 32'h1F;
        if (s >= -2048 && s <= 2047) begin
          w.instr = ((imm & 32'hFFF) << 20) | (rd << 7) | 32'h13;
          exp_q.push_back(w);
        end else begin
          t = s <<< 20;
          lo = t >>> 20;
          hi = imm - 32'(lo);
          w.instr = (hi & 32'hFFFFF000) | (rd << 7) | 32'h37;
          w.last = (lo == 0);
          exp_q.push_back(w);
          if (lo != 0) begin
            w.instr = ((imm & 32'hFFF) << 20) | (rd << 15) | (rd << 7) | 32'h13;
            w.last = 1'b1;
            exp_q.push_back(w);
          end
        end
        return;
      end
      default: begin
        w.instr = base;
        w.err = 1'b1;
      end
    endcase
    exp_q.push_back(w);
  endfunction

  function automatic logic [2:0] rand_fmt();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 4) return 3'(r);
    if (r <= 7) return 3'd7;
    return (r == 8) ? 3'd5 : 3'd6;
  endfunction

  function automatic logic [31:0] rand_imm();
    int v;
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: begin v = int'($urandom_range(0, 6000)) - 3000; return 32'(v); end
      2: begin
        v = 1048570 + int'($urandom_range(0, 8));
        if ($urandom_range(0, 1) == 1) v = -v;
        return 32'(v);
      end
      3: return $urandom & 32'hFFFFF000;
      default: return $urandom & 32'h00001FFE;
    endcase
  endfunction

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset: valid=%b instr=%h err=%b last=%b in_ready=%b, required all zero",
               out_valid, out_instr, out_err, out_last, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
    end
  endtask

  localparam int NT = 15;
  localparam logic [2:0]  T_FMT [NT] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd1, 3'd5, 3'd7, 3'd7, 3'd2, 3'd6};
  localparam logic [31:0] T_BASE[NT] = '{32'h293, 32'h293, 32'h293, 32'h63, 32'h63, 32'hEF, 32'hEF, 32'hEF,
                                          32'h37, 32'h00512023, 32'h1234, 32'h80, 32'h80, 32'h63, 32'h00ABCDEF};
  localparam logic [31:0] T_IMM [NT] = '{32'hFFFFFFFF, 32'h800, 32'hFFFFF800, 32'hFFFFFFFC, 32'h3, 32'h800,
                                          32'h000FFFFE, 32'h00100000, 32'h12345001, 32'hFFFFFFF8, 32'h5,
                                          32'h1000, 32'h64, 32'hFFE, 32'h0};
  localparam logic [31:0] T_OUT [NT] = '{32'hFFF00293, 32'h80000293, 32'h80000293, 32'hFE000EE3, 32'h00000163,
                                          32'h001000EF, 32'h7FFFF0EF, 32'h800000EF, 32'h12345037, 32'hFE512C23,
                                          32'h00001234, 32'h000010B7, 32'h06400093, 32'h7E000FE3, 32'h00ABCDEF};
  localparam logic        T_ERR [NT] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                          1'b0, 1'b0, 1'b0, 1'b1};

  task automatic test_directed();
    int waited;
    for (int i = 0; i < NT; i++) begin
      @(negedge clk);
      in_fmt = T_FMT[i];
      in_base = T_BASE[i];
      in_imm = T_IMM[i];
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      waited = 0;
      while (!in_ready && waited < 10) begin
        @(negedge clk);
        #1;
        waited++;
      end
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL directed[%0d] accept timeout: in_ready=%b, required 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_instr !== T_OUT[i] || out_err !== T_ERR[i] || out_last !== 1'b1) begin
        n_err++;
        $display("FAIL directed[%0d]: valid=%b instr=%h err=%b last=%b, required 1 %h %b 1",
                 i, out_valid, out_instr, out_err, out_last, T_OUT[i], T_ERR[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    drain();
    in_fmt = 3'd7;
    in_base = 32'h00000500;
    in_imm = 32'h12345FFF;
    in_valid = 1'b1;
    out_ready = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_accept: in_ready=%b, required 1", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_fmt = 3'd0;
      in_base = $urandom;
      in_imm = $urandom;
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || out_instr !== 32'h12346537 || out_last !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: valid=%b instr=%h last=%b err=%b in_ready=%b, required 1 12346537 0 0 0",
                 c, out_valid, out_instr, out_last, out_err, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFFF50513 || out_last !== 1'b1 || out_err !== 1'b0) begin
      n_err++;
      $display("FAIL bp_addi: valid=%b instr=%h last=%b err=%b, required 1 fff50513 1 0",
               out_valid, out_instr, out_last, out_err);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_no_dup: valid=%b instr=%h, required valid 0", out_valid, out_instr);
    end
  endtask

  task automatic test_back_to_back();
    word_t w;
    drain();
    exp_q.delete();
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 4) begin
        in_fmt = 3'd0;
        in_base = 32'h00000013 | (32'(k + 1) << 7);
        in_imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k > 0) begin
        w = exp_q.pop_front();
        n_vec++;
        if (out_valid !== 1'b1 || out_instr !== w.instr || out_err !== w.err || out_last !== w.last) begin
          n_err++;
          $display("FAIL b2b[%0d]: valid=%b instr=%h err=%b last=%b, required 1 %h %b %b",
                   k - 1, out_valid, out_instr, out_err, out_last, w.instr, w.err, w.last);
        end
      end
      if (k < 4) begin
        n_vec++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_ready[%0d]: in_ready=%b, required 1", k, in_ready);
        end
        model(in_fmt, in_base, in_imm);
      end
    end
  endtask

  task automatic test_reset_mid_li();
    drain();
    in_fmt = 3'd7;
    in_base = 32'h00000500;
    in_imm = 32'h12345FFF;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_last !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_li_setup: valid=%b last=%b in_ready=%b, required 1 0 0", out_valid, out_last, in_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_li_clear: valid=%b instr=%h in_ready=%b, required 0 0 0", out_valid, out_instr, in_ready);
    end
    reset = 1'b0;
    out_ready = 1'b1;
    in_fmt = 3'd0;
    in_base = 32'h00000293;
    in_imm = 32'h5;
    in_valid = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_li_idle: in_ready=%b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || out_instr !== 32'h00500293 || out_last !== 1'b1 || out_err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_li_next: valid=%b instr=%h last=%b err=%b, required 1 00500293 1 0",
               out_valid, out_instr, out_last, out_err);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rst_li_stale[%0d]: valid=%b instr=%h, required valid 0", c, out_valid, out_instr);
      end
    end
  endtask

  task automatic test_random(input int cycles);
    word_t w;
    logic        stalled;
    logic [31:0] held;
    drain();
    exp_q.delete();
    stalled = 1'b0;
    held = '0;
    for (int c = 0; c < cycles + 40; c++) begin
      @(negedge clk);
      if (c < cycles) begin
        out_ready = ($urandom_range(0, 3) != 0);
        in_valid = ($urandom_range(0, 2) != 0);
        in_fmt = rand_fmt();
        in_base = $urandom;
        in_imm = rand_imm();
      end else begin
        out_ready = 1'b1;
        in_valid = 1'b0;
      end
      #1;
      if (stalled) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_instr !== held) begin
          n_err++;
          $display("FAIL random_hold[%0d]: valid=%b instr=%h, required 1 %h", c, out_valid, out_instr, held);
        end
      end
      stalled = out_valid && !out_ready;
      held = out_instr;
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL random_extra[%0d]: instr=%h, required no word", c, out_instr);
        end else begin
          w = exp_q.pop_front();
          if (out_instr !== w.instr || out_err !== w.err || out_last !== w.last) begin
            n_err++;
            $display("FAIL random[%0d]: instr=%h err=%b last=%b, required %h %b %b",
                     c, out_instr, out_err, out_last, w.instr, w.err, w.last);
          end
        end
      end
      if (in_valid && in_ready) model(in_fmt, in_base, in_imm);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL random_lost: %0d words outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_li();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
